// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, halt encoding and fetch FSM state encoding for the instruction fetch unit.
// The halt word doubles as the value returned by unprogrammed instruction memory.
package instruction_fetch_unit_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] HALT_WORD = 16'h0000;

    localparam int BUF_DEPTH = 2;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Two-entry in-order buffer of {pc, instr}; entry 0 is always the head.
// Flush empties the buffer outright and takes priority over push and pop.
module fetch_buffer #(
    parameter int ADDR_W = instruction_fetch_unit_pkg::ADDR_W,
    parameter int DATA_W = instruction_fetch_unit_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_instr_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_instr_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        count_o
);

    import instruction_fetch_unit_pkg::*;

    logic [ADDR_W-1:0] ent0_pc_q, ent0_pc_d;
    logic [DATA_W-1:0] ent0_instr_q, ent0_instr_d;
    logic [ADDR_W-1:0] ent1_pc_q, ent1_pc_d;
    logic [DATA_W-1:0] ent1_instr_q, ent1_instr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        ent0_pc_d    = ent0_pc_q;
        ent0_instr_d = ent0_instr_q;
        ent1_pc_d    = ent1_pc_q;
        ent1_instr_d = ent1_instr_q;
        count_d      = count_q;
        do_pop       = pop_i && (count_q != 2'd0);
        do_push      = push_i && ((count_q != 2'(BUF_DEPTH)) || do_pop);

        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b01: begin
                    ent0_pc_d    = ent1_pc_q;
                    ent0_instr_d = ent1_instr_q;
                    count_d      = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_pc_d    = push_pc_i;
                        ent0_instr_d = push_instr_i;
                    end else begin
                        ent1_pc_d    = push_pc_i;
                        ent1_instr_d = push_instr_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        ent0_pc_d    = push_pc_i;
                        ent0_instr_d = push_instr_i;
                    end else begin
                        ent0_pc_d    = ent1_pc_q;
                        ent0_instr_d = ent1_instr_q;
                        ent1_pc_d    = push_pc_i;
                        ent1_instr_d = push_instr_i;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent0_pc_q    <= '0;
            ent0_instr_q <= '0;
            ent1_pc_q    <= '0;
            ent1_instr_q <= '0;
            count_q      <= 2'd0;
        end else begin
            ent0_pc_q    <= ent0_pc_d;
            ent0_instr_q <= ent0_instr_d;
            ent1_pc_q    <= ent1_pc_d;
            ent1_instr_q <= ent1_instr_d;
            count_q      <= count_d;
        end
    end

    assign head_pc_o    = ent0_pc_q;
    assign head_instr_o = ent0_instr_q;
    assign full_o       = (count_q == 2'(BUF_DEPTH));
    assign empty_o      = (count_q == 2'd0);
    assign count_o      = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetcher: pc and RUN/HALTED FSM drive a combinational imem,
// fetched words go through a two-entry buffer to a valid/ready consumer.
module instruction_fetch_unit #(
    parameter int                ADDR_W    = instruction_fetch_unit_pkg::ADDR_W,
    parameter int                DATA_W    = instruction_fetch_unit_pkg::DATA_W,
    parameter logic [DATA_W-1:0] HALT_WORD = instruction_fetch_unit_pkg::HALT_WORD
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              halted,
    output logic              dbg_state_o,
    output logic [1:0]        dbg_fill_o
);

    import instruction_fetch_unit_pkg::*;

    // Handshake: a word moves to the consumer on any rising edge where
    // out_valid and out_ready are both 1; out_pc/out_instr hold while stalled.

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halted_q;

    logic buf_full;
    logic buf_empty;
    logic pop;
    logic fetch_en;
    logic is_halt;
    logic push;

    assign pop      = out_valid && out_ready;
    assign is_halt  = (imem_data == HALT_WORD);
    assign fetch_en = (state_q == ST_RUN) && !redirect && (!buf_full || pop);
    assign push     = fetch_en && !is_halt;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (push) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // Redirect outranks the halt word seen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (redirect) begin
                state_q  <= ST_RUN;
                halted_q <= 1'b0;
            end else if (fetch_en && is_halt) begin
                state_q  <= ST_HALTED;
                halted_q <= 1'b1;
            end
        end
    end

    fetch_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fetch_buffer (
        .clk_i        (clk),
        .rst_i        (reset),
        .push_i       (push),
        .push_pc_i    (pc_q),
        .push_instr_i (imem_data),
        .pop_i        (pop),
        .flush_i      (redirect),
        .head_pc_o    (out_pc),
        .head_instr_o (out_instr),
        .full_o       (buf_full),
        .empty_o      (buf_empty),
        .count_o      (dbg_fill_o)
    );

    assign imem_address = pc_q;
    assign out_valid    = !buf_empty;
    assign halted       = halted_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the fetch rules.
module tb_instruction_fetch_unit;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int EW = AW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] imem_address;
    logic [DW-1:0] imem_data;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          out_valid;
    logic          out_ready;
    logic          redirect;
    logic [AW-1:0] redirect_target;
    logic          halted;
    logic          dbg_state;
    logic [1:0]    dbg_fill;

    logic [DW-1:0] mem [256];
    assign imem_data = mem[imem_address];

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_data       (imem_data),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halted          (halted),
        .dbg_state_o     (dbg_state),
        .dbg_fill_o      (dbg_fill)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: buffered words, fetch address, halted flag.
    logic [EW-1:0] m_q[$];
    logic [AW-1:0] m_pc;
    bit            m_halted;
    // Scoreboard: transfers predicted by the model vs. transfers seen on the DUT.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];

    task automatic load_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h485A;
        mem[1] = 16'h4A14;
        mem[2] = 16'h4DF6;
        mem[3] = 16'h4F96;
        mem[4] = 16'h0880;
    endtask

    task automatic model_step(input bit r, input bit rdy, input bit rd, input logic [AW-1:0] tgt);
        logic [DW-1:0] w;
        if (r) begin
            m_q.delete();
            m_pc     = '0;
            m_halted = 1'b0;
            return;
        end
        if (m_q.size() > 0 && rdy) exp_q.push_back(m_q.pop_front());
        if (rd) begin
            m_q.delete();
            m_pc     = tgt;
            m_halted = 1'b0;
        end else if (!m_halted && m_q.size() < 2) begin
            w = mem[m_pc];
            if (w == 16'h0000) begin
                m_halted = 1'b1;
            end else begin
                m_q.push_back({m_pc, w});
                m_pc = m_pc + 8'd1;
            end
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic tick(input bit r, input bit rdy, input bit rd, input logic [AW-1:0] tgt);
        reset           = r;
        out_ready       = rdy;
        redirect        = rd;
        redirect_target = tgt;
        #1;
        if (!r && out_valid === 1'b1 && rdy) got_q.push_back({out_pc, out_instr});
        model_step(r, rdy, rd, tgt);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_scenario();
        got_q.delete();
        exp_q.delete();
        tick(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        redirect = 1'b1;
        out_ready = 1'b1;
        tick(1'b1, 1'b1, 1'b1, 8'h33);
        tick(1'b1, 1'b1, 1'b1, 8'h33);
        vectors++;
        if ({out_valid, halted, dbg_state, dbg_fill} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b halted=%b state=%b fill=%0d, want all 0",
                     out_valid, halted, dbg_state, dbg_fill);
        end
        vectors++;
        if ({imem_address, out_pc, out_instr} !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: got addr=%h pc=%h instr=%h, want 00/00/0000",
                     imem_address, out_pc, out_instr);
        end
    endtask

    task automatic test_stream();
        logic [EW-1:0] lit [5] = '{24'h00485A, 24'h014A14, 24'h024DF6, 24'h034F96, 24'h040880};
        start_scenario();
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h00);
            vectors++;
            if ({out_valid, halted, imem_address, dbg_fill} !== {m_q.size() != 0, m_halted, m_pc, 2'(m_q.size())}) begin
                errors++;
                $display("FAIL stream_state c%0d: got v=%b h=%b addr=%h fill=%0d, want v=%b h=%b addr=%h fill=%0d",
                         c, out_valid, halted, imem_address, dbg_fill, m_q.size() != 0, m_halted, m_pc, m_q.size());
            end
            if (m_q.size() != 0) begin
                vectors++;
                if ({out_pc, out_instr} !== m_q[0]) begin
                    errors++;
                    $display("FAIL stream_head c%0d: got %h, want %h", c, {out_pc, out_instr}, m_q[0]);
                end
            end
        end
        vectors++;
        if (got_q.size() != 5) begin
            errors++;
            $display("FAIL stream_count: got %0d transfers, want 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (got_q[i] !== lit[i]) begin
                    errors++;
                    $display("FAIL stream_word%0d: got %h, want %h", i, got_q[i], lit[i]);
                end
            end
        end
        vectors++;
        if ({halted, dbg_state, out_valid, imem_address} !== {1'b1, 1'b1, 1'b0, 8'h05}) begin
            errors++;
            $display("FAIL stream_halt: got h=%b st=%b v=%b addr=%h, want 1/1/0/05",
                     halted, dbg_state, out_valid, imem_address);
        end
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] lit [3] = '{24'h00485A, 24'h014A14, 24'h024DF6};
        start_scenario();
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 1'b0, 1'b0, 8'h00);
            vectors++;
            if ({out_valid, imem_address, dbg_fill} !== {m_q.size() != 0, m_pc, 2'(m_q.size())}) begin
                errors++;
                $display("FAIL stall_state c%0d: got v=%b addr=%h fill=%0d, want v=%b addr=%h fill=%0d",
                         c, out_valid, imem_address, dbg_fill, m_q.size() != 0, m_pc, m_q.size());
            end
        end
        vectors++;
        if ({out_valid, out_pc, out_instr, imem_address, dbg_fill} !== {1'b1, 8'h00, 16'h485A, 8'h02, 2'd2}) begin
            errors++;
            $display("FAIL stall_hold: got v=%b pc=%h instr=%h addr=%h fill=%0d, want 1/00/485A/02/2",
                     out_valid, out_pc, out_instr, imem_address, dbg_fill);
        end
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b1, 1'b0, 8'h00);
        vectors++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL release_count: got %0d transfers in 3 cycles, want 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (got_q[i] !== lit[i]) begin
                    errors++;
                    $display("FAIL release_word%0d: got %h, want %h", i, got_q[i], lit[i]);
                end
            end
        end
    endtask

    task automatic test_redirect_halted();
        start_scenario();
        for (int c = 0; c < 8; c++) tick(1'b0, 1'b1, 1'b0, 8'h00);
        vectors++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halted_before_redirect: got %b, want 1", halted);
        end
        tick(1'b0, 1'b1, 1'b1, 8'h02);
        vectors++;
        if ({halted, dbg_state, imem_address} !== {1'b0, 1'b0, 8'h02}) begin
            errors++;
            $display("FAIL redirect_unhalt: got h=%b st=%b addr=%h, want 0/0/02", halted, dbg_state, imem_address);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        vectors++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 8'h02, 16'h4DF6}) begin
            errors++;
            $display("FAIL redirect_first: got v=%b %h/%h, want 1 02/4DF6", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_redirect_full();
        start_scenario();
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (dbg_fill !== 2'd2) begin
            errors++;
            $display("FAIL flush_prefill: got fill=%0d, want 2", dbg_fill);
        end
        tick(1'b0, 1'b1, 1'b1, 8'h00);
        vectors++;
        if ({out_valid, imem_address} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL flush_empty: got v=%b addr=%h, want 0/00", out_valid, imem_address);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        vectors++;
        if (got_q.size() != 2 || got_q[0] !== 24'h00485A || got_q[1] !== 24'h00485A) begin
            errors++;
            $display("FAIL flush_order: got %0d transfers first=%h second=%h, want 00485A then 00485A",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 24'h0, got_q.size() > 1 ? got_q[1] : 24'h0);
        end
    endtask

    task automatic test_wrap();
        mem[255] = 16'h1234;
        start_scenario();
        tick(1'b0, 1'b1, 1'b1, 8'hFF);
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 1'b0, 8'h00);
        vectors++;
        if (got_q.size() < 2 || got_q[0] !== 24'hFF1234 || got_q[1] !== 24'h00485A) begin
            errors++;
            $display("FAIL wrap_order: got %0d transfers first=%h second=%h, want FF1234 then 00485A",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 24'h0, got_q.size() > 1 ? got_q[1] : 24'h0);
        end
        mem[255] = 16'h0000;
    endtask

    task automatic test_mid_reset();
        start_scenario();
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b1, 1'b1, 8'h03);
        vectors++;
        if ({out_valid, imem_address, halted} !== {1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL midreset_clear: got v=%b addr=%h h=%b, want 0/00/0", out_valid, imem_address, halted);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        vectors++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 8'h00, 16'h485A}) begin
            errors++;
            $display("FAIL midreset_resume: got v=%b %h/%h, want 1 00/485A", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_random();
        bit            r, rdy, rd;
        logic [AW-1:0] tgt;
        for (int a = 0; a < 16; a++)
            mem[a] = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
        start_scenario();
        for (int c = 0; c < 400; c++) begin
            r   = ($urandom_range(0, 63) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 11) == 0);
            tgt = 8'($urandom_range(0, 9));
            if (tgt > 8'd7) tgt = tgt + 8'hF6;
            tick(r, rdy, rd, tgt);
            vectors++;
            if ({out_valid, halted, imem_address, dbg_fill} !== {m_q.size() != 0, m_halted, m_pc, 2'(m_q.size())}) begin
                errors++;
                $display("FAIL rand_state c%0d: got v=%b h=%b addr=%h fill=%0d, want v=%b h=%b addr=%h fill=%0d",
                         c, out_valid, halted, imem_address, dbg_fill, m_q.size() != 0, m_halted, m_pc, m_q.size());
            end
            if (m_q.size() != 0) begin
                vectors++;
                if ({out_pc, out_instr} !== m_q[0]) begin
                    errors++;
                    $display("FAIL rand_head c%0d: got %h, want %h", c, {out_pc, out_instr}, m_q[0]);
                end
            end
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_xfer_count: got %0d, want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_xfer%0d: got %h, want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        load_mem();
    endtask

    initial begin
        reset           = 1'b1;
        out_ready       = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;
        load_mem();
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_halted();
        test_redirect_full();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter ADDR_W, 8, instruction address width.
REQ-002 Parameter DATA_W, 16, instruction word width.
REQ-003 Parameter HALT_WORD, 16'h0000, word that stops fetching; it is also the unprogrammed-memory default.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 imem_address  output  ADDR_W  address driven to the combinational instruction memory; equals the internal pc.
REQ-007 imem_data  input  DATA_W  memory word for imem_address, valid in the same cycle.
REQ-008 out_instr  output  DATA_W  instruction at the head of the buffer.
REQ-009 out_pc  output  ADDR_W  address of out_instr.
REQ-010 out_valid  output  1  buffer head holds a valid instruction.
REQ-011 out_ready  input  1  consumer accepts the head; a transfer occurs when out_valid and out_ready are both 1.
REQ-012 redirect  input  1  one-cycle request to restart fetch at redirect_target.
REQ-013 redirect_target  input  ADDR_W  new fetch address.
REQ-014 halted  output  1  fetch stopped on HALT_WORD.

Function
REQ-015 The FSM SHALL have two states, RUN and HALTED.
REQ-016 The buffer SHALL be a 2-entry FIFO of {pc, instr}, with out_* driven from the head entry and no combinational path from imem_data to out_*.
REQ-017 A fetch SHALL occur in RUN when redirect=0 and the FIFO has space (count<2, or count=2 with a transfer this cycle).
REQ-018 On a fetch of a word not equal to HALT_WORD, the unit SHALL enqueue {pc, imem_data} and set pc to pc+1 modulo 2^ADDR_W (8'hFF wraps to 8'h00).
REQ-019 On a fetch of HALT_WORD, the unit SHALL not enqueue, SHALL hold pc, SHALL go to HALTED, and SHALL set halted=1 from the next cycle.
REQ-020 In HALTED, the unit SHALL not fetch, and the FIFO SHALL keep draining through normal handshakes.
REQ-021 Latency SHALL be one cycle: a word fetched in cycle N is visible on out_* in cycle N+1 if the FIFO was empty.
REQ-022 Throughput SHALL be one instruction per cycle while out_ready=1.
REQ-023 With out_valid=1 and out_ready=0, out_instr and out_pc SHALL hold stable.
REQ-024 Redirect SHALL have priority over fetch and halt. In a redirect cycle, any transfer occurring that cycle completes, all remaining FIFO entries are discarded, pc is set to redirect_target, the state goes to RUN, halted is cleared, and no fetch occurs.
REQ-025 After a redirect, the first word SHALL be fetched in the following cycle and appear on out_* one cycle later.
REQ-026 Simultaneous enqueue and dequeue on a full FIFO SHALL keep count=2 with order preserved.

Reset
REQ-027 On reset=1: pc=0, FIFO empty (out_valid=0), state=RUN, halted=0, out_instr=0, out_pc=0.
REQ-028 Reset SHALL override redirect and any handshake in the same cycle.
REQ-029 Mid-operation reset SHALL discard buffered instructions, and fetch SHALL resume at address 0 in the first cycle after reset deasserts.

Structure
REQ-030 The shared package SHALL hold ADDR_W, DATA_W, HALT_WORD, and the state encoding (RUN=0, HALTED=1).
REQ-031 The FIFO SHALL be one sub-module, fetch_buffer (2-entry, with push, pop, flush, full, empty, and count outputs); the pc and FSM live in the top module.

Verification
REQ-032 The bench SHALL use a memory model with 0x00=485A, 0x01=4A14, 0x02=4DF6, 0x03=4F96, 0x04=0880, and all other addresses 0000.
REQ-033 Scenario: reset, then out_ready=1 held -> five consecutive transfers (pc 0..4) with instr 485A, 4A14, 4DF6, 4F96, 0880; halted=1 the cycle after address 5 is fetched; out_valid=0 afterwards.
REQ-034 Scenario: out_ready=0 for 5 cycles after reset -> FIFO holds 485A and 4A14, out_instr stays 485A, imem_address stays 02; releasing out_ready yields 485A, 4A14, 4DF6 in order with no gap or duplicate.
REQ-035 Scenario: while halted, redirect=1 with target 02 -> halted=0 next cycle, then out_pc=02 with out_instr=4DF6 two cycles after the redirect.
REQ-036 Scenario: FIFO full and redirect with target 00 in the same cycle as a transfer -> the head transfer completes, the other entry is discarded, and the next delivered instruction is 485A at pc 00.
REQ-037 Scenario: memory model with 0xFF=1234 and 0x00=485A, redirect to FF -> outputs FF/1234 then 00/485A (wrap).
REQ-038 Scenario: reset asserted for one cycle with two entries buffered -> out_valid=0 the next cycle, then 00/485A one cycle after that.
